wino_atza_22_21_seq: RTL and testbench

- Streaming sequencer for the 3x2 -> 2x2 Winograd output transform (AT*Z*A, F(2x2) from a 3x2 tile).
- Accepts one tile element per beat over a valid/ready input, assembles 6-word tiles, and applies the transform on a buffered tile.
- Streams the 4 results one per beat over a valid/ready output.
- Sits between the element-wise product stage and the output-tile writeback. Double-buffered so loading tile k+1 overlaps draining tile k.

---
 rtl/wino_atza_22_21_seq.sv | 96 +++++++++
 tb/tb_wino_atza_22_21_seq.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wino_atza_22_21_seq.sv
// Winograd F(2x2) output-transform sequencer: 6-word tiles in, 4 results out, one word per beat.
// First result 2 cycles after the last element; in_ready drops while a loaded tile waits for the drain side.
module wino_atza_22_21_seq #(
   parameter int data_width = 20,
   parameter int cnt_width  = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [data_width-1:0] in_data,
   input  logic                  in_last,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [data_width-1:0] out_data,
   output logic                  out_last,
   output logic [cnt_width-1:0]  tile_cnt,
   output logic                  err_framing
);

   logic [5:0][data_width-1:0] ld_dat;
   logic [2:0]                 ld_idx;
   logic                       load_full;
   logic                       load_last;
   logic [3:0][data_width-1:0] res_dat;
   logic [1:0]                 out_idx;
   logic                       out_busy;
   logic                       out_last_r;

   logic accept;
   logic out_fire;
   logic drain_done;
   logic xfer;

   assign in_ready   = !load_full;
   assign accept     = in_valid && in_ready;
   assign out_fire   = out_busy && out_ready;
   assign drain_done = out_fire && (out_idx == 2'd3);
   // The load bank may hand over in the same cycle the last result leaves.
   assign xfer       = load_full && (!out_busy || drain_done);

   assign out_valid = out_busy;
   assign out_data  = res_dat[out_idx];
   assign out_last  = out_busy && (out_idx == 2'd3) && out_last_r;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ld_dat      <= '0;
         ld_idx      <= 3'd0;
         load_full   <= 1'b0;
         load_last   <= 1'b0;
         res_dat     <= '0;
         out_idx     <= 2'd0;
         out_busy    <= 1'b0;
         out_last_r  <= 1'b0;
         tile_cnt    <= '0;
         err_framing <= 1'b0;
      end else begin
         if (accept) begin
            ld_dat[ld_idx] <= in_data;
            if (ld_idx == 3'd5) begin
               ld_idx    <= 3'd0;
               load_full <= 1'b1;
               load_last <= in_last;
            end else begin
               ld_idx <= ld_idx + 3'd1;
               if (in_last) begin
                  err_framing <= 1'b1;
               end
            end
         end

         if (out_fire) begin
            out_idx <= out_idx + 2'd1;
         end

         if (drain_done) begin
            tile_cnt <= tile_cnt + 1'b1;
            out_busy <= 1'b0;
         end

         // Later assignments win: a coinciding transfer keeps out_busy set and restarts the index.
         if (xfer) begin
            res_dat[0] <= ld_dat[0] + ld_dat[2];
            res_dat[1] <= ld_dat[1] + ld_dat[3];
            res_dat[2] <= ld_dat[0] - ld_dat[2] + ld_dat[4];
            res_dat[3] <= ld_dat[1] - ld_dat[3] + ld_dat[5];
            out_last_r <= load_last;
            out_busy   <= 1'b1;
            out_idx    <= 2'd0;
            load_full  <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_wino_atza_22_21_seq.sv
// Bench for wino_atza_22_21_seq: directed tile table plus a randomized run against a queue-based tile model.
module tb_wino_atza_22_21_seq;

   localparam int DW = 20;
   localparam int CW = 16;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [DW-1:0] in_data = '0;
   logic          in_last = 1'b0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [DW-1:0] out_data;
   logic          out_last;
   logic [CW-1:0] tile_cnt;
   logic          err_framing;

   always #5 clk = ~clk;

   wino_atza_22_21_seq #(.data_width(DW), .cnt_width(CW)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_data     (in_data),
      .in_last     (in_last),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data),
      .out_last    (out_last),
      .tile_cnt    (tile_cnt),
      .err_framing (err_framing)
   );

   typedef struct packed {
      logic [5:0][DW-1:0] d;
      logic [3:0][DW-1:0] r;
   } vec_t;

   typedef struct packed {
      logic [DW-1:0] dat;
      logic          last;
   } beat_t;

   int checks = 0;
   int failures = 0;

   vec_t          vecs [5];
   logic [DW-1:0] part_q [$];
   beat_t         exp_q [$];
   beat_t         obs_q [$];
   int            beats = 0;
   logic          m_err = 1'b0;
   logic          rst_seen = 1'b0;
   logic          prev_stall = 1'b0;
   beat_t         prev_beat;
   beat_t         mb;
   logic [DW-1:0] m0, m1, m2, m3;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
      end
   endtask

   function automatic vec_t mk(input logic [DW-1:0] a0, a1, a2, a3, a4, a5,
                               input logic [DW-1:0] r0, r1, r2, r3);
      vec_t v;
      v.d[0] = a0; v.d[1] = a1; v.d[2] = a2; v.d[3] = a3; v.d[4] = a4; v.d[5] = a5;
      v.r[0] = r0; v.r[1] = r1; v.r[2] = r2; v.r[3] = r3;
      return v;
   endfunction

   function automatic beat_t mkbeat(input logic [DW-1:0] d, input logic l);
      beat_t b;
      b.dat  = d;
      b.last = l;
      return b;
   endfunction

   // Reference model: tiles are rebuilt from accepted words, results queued in output order.
   always @(negedge clk) begin
      if (rst_seen) begin
         check("tile_cnt_track", 32'(tile_cnt), 32'((beats / 4) % (1 << CW)));
         check("err_framing_track", 32'(err_framing), 32'(m_err));
         if (prev_stall) begin
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_data", 32'(out_data), 32'(prev_beat.dat));
            check("hold_last", 32'(out_last), 32'(prev_beat.last));
         end
      end
      if (!rst_n) begin
         part_q.delete();
         exp_q.delete();
         beats      = 0;
         m_err      = 1'b0;
         prev_stall = 1'b0;
         rst_seen   = 1'b1;
      end else if (rst_seen) begin
         prev_stall = out_valid && !out_ready;
         prev_beat  = mkbeat(out_data, out_last);
         if (out_valid && out_ready) begin
            obs_q.push_back(mkbeat(out_data, out_last));
            if (exp_q.size() == 0) begin
               check("unexpected_beat", 32'd1, 32'd0);
            end else begin
               mb = exp_q.pop_front();
               check("model_data", 32'(out_data), 32'(mb.dat));
               check("model_last", 32'(out_last), 32'(mb.last));
            end
            beats++;
         end
         if (in_valid && in_ready) begin
            if (in_last && part_q.size() < 5) m_err = 1'b1;
            part_q.push_back(in_data);
            if (part_q.size() == 6) begin
               m0 = part_q[0] + part_q[2];
               m1 = part_q[1] + part_q[3];
               m2 = part_q[0] - part_q[2] + part_q[4];
               m3 = part_q[1] - part_q[3] + part_q[5];
               exp_q.push_back(mkbeat(m0, 1'b0));
               exp_q.push_back(mkbeat(m1, 1'b0));
               exp_q.push_back(mkbeat(m2, 1'b0));
               exp_q.push_back(mkbeat(m3, in_last));
               part_q.delete();
            end
         end
      end
   end

   // Called and returns just after a rising edge.
   task automatic send_word(input logic [DW-1:0] d, input logic l);
      int w = 0;
      in_valid = 1'b1;
      in_data  = d;
      in_last  = l;
      @(negedge clk);
      while (!in_ready && w < 200) begin
         @(negedge clk);
         w++;
      end
      if (!in_ready) check("send_timeout", 32'd0, 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic send_tile(input vec_t v, input int last_pos);
      for (int k = 0; k < 6; k++) send_word(v.d[k], k == last_pos);
   endtask

   task automatic wait_beats(input int n);
      int w = 0;
      while (obs_q.size() < n && w < 300) begin
         @(negedge clk);
         w++;
      end
      check("beats_arrived", 32'(obs_q.size() >= n), 32'd1);
      @(posedge clk); #1;
   endtask

   task automatic pop_check(input string nm, input logic [DW-1:0] d, input logic l);
      beat_t b;
      b = '1;
      if (obs_q.size() > 0) b = obs_q.pop_front();
      check({nm, "_data"}, 32'(b.dat), 32'(d));
      check({nm, "_last"}, 32'(b.last), 32'(l));
   endtask

   task automatic do_reset();
      rst_n    = 1'b0;
      in_valid = 1'b0;
      in_last  = 1'b0;
      repeat (2) begin
         @(posedge clk); #1;
      end
      rst_n = 1'b1;
      obs_q.delete();
   endtask

   initial begin
      #2000000;
      failures++;
      $display("FAIL watchdog actual=timeout required=finish");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

   initial begin
      int w;
      vecs[0] = mk(20'd1, 20'd2, 20'd3, 20'd4, 20'd5, 20'd6, 20'd4, 20'd6, 20'd3, 20'd4);
      vecs[1] = mk(20'hFFFFF, 20'd0, 20'd1, 20'd0, 20'd0, 20'd0,
                   20'h00000, 20'h00000, 20'hFFFFE, 20'h00000);
      vecs[2] = mk(20'd10, 20'd20, 20'd30, 20'd40, 20'd50, 20'd60,
                   20'd40, 20'd60, 20'd30, 20'd40);
      vecs[3] = mk(20'd0, 20'd0, 20'd5, 20'd7, 20'd0, 20'd0,
                   20'd5, 20'd7, 20'hFFFFB, 20'hFFFF9);
      vecs[4] = mk(20'h80000, 20'h7FFFF, 20'h80000, 20'h00001, 20'h00003, 20'h00002,
                   20'h00000, 20'h80000, 20'h00003, 20'h80000);

      do_reset();
      @(negedge clk);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_data", 32'(out_data), 32'd0);
      check("rst_out_last", 32'(out_last), 32'd0);
      check("rst_tile_cnt", 32'(tile_cnt), 32'd0);
      check("rst_err", 32'(err_framing), 32'd0);
      @(posedge clk); #1;

      // Table: each tile in isolation, with first-output latency.
      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         obs_q.delete();
         send_tile(vecs[i], -1);
         @(negedge clk);
         check("lat_not_yet_valid", 32'(out_valid), 32'd0);
         check("load_full_in_ready", 32'(in_ready), 32'd0);
         @(posedge clk); #1;
         @(negedge clk);
         check("lat_first_valid", 32'(out_valid), 32'd1);
         check("lat_first_data", 32'(out_data), 32'(vecs[i].r[0]));
         wait_beats(4);
         for (int j = 0; j < 4; j++) pop_check("table", vecs[i].r[j], 1'b0);
      end
      @(negedge clk);
      check("table_tile_cnt", 32'(tile_cnt), 32'd5);
      @(posedge clk); #1;

      // Back-pressure: two tiles pile up, then drain with no bubble.
      do_reset();
      out_ready = 1'b0;
      send_tile(vecs[0], -1);
      send_tile(vecs[2], -1);
      @(negedge clk);
      check("bp_in_ready_low", 32'(in_ready), 32'd0);
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_held_data", 32'(out_data), 32'd4);
      repeat (10) @(negedge clk);
      check("bp_in_ready_still_low", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
      out_ready = 1'b1;
      for (int j = 0; j < 8; j++) begin
         @(negedge clk);
         check("bp_no_bubble", 32'(out_valid), 32'd1);
      end
      wait_beats(8);
      for (int j = 0; j < 4; j++) pop_check("bp_tile0", vecs[0].r[j], 1'b0);
      for (int j = 0; j < 4; j++) pop_check("bp_tile1", vecs[2].r[j], 1'b0);
      @(negedge clk);
      check("bp_tile_cnt", 32'(tile_cnt), 32'd2);
      check("bp_idle", 32'(out_valid), 32'd0);
      @(posedge clk); #1;

      // Back-to-back input over 4 tiles.
      do_reset();
      out_ready = 1'b1;
      for (int t = 0; t < 4; t++) send_tile(vecs[t], -1);
      wait_beats(16);
      for (int t = 0; t < 4; t++)
         for (int j = 0; j < 4; j++) pop_check("b2b", vecs[t].r[j], 1'b0);
      @(negedge clk);
      check("b2b_tile_cnt", 32'(tile_cnt), 32'd4);
      @(posedge clk); #1;

      // Framing: misplaced in_last flags an error, proper one marks dout3.
      do_reset();
      out_ready = 1'b1;
      send_tile(vecs[0], 2);
      @(negedge clk);
      check("framing_err_set", 32'(err_framing), 32'd1);
      @(posedge clk); #1;
      send_tile(vecs[2], 5);
      wait_beats(8);
      for (int j = 0; j < 4; j++) pop_check("frm_tile0", vecs[0].r[j], 1'b0);
      for (int j = 0; j < 4; j++) pop_check("frm_tile1", vecs[2].r[j], j == 3);
      repeat (5) @(negedge clk);
      check("framing_err_sticky", 32'(err_framing), 32'd1);
      @(posedge clk); #1;

      // Reset while tile 1 drains and tile 2 is partly loaded.
      do_reset();
      out_ready = 1'b1;
      send_tile(vecs[0], -1);
      for (int k = 0; k < 3; k++) send_word(vecs[2].d[k], 1'b0);
      rst_n = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      check("midrst_out_valid", 32'(out_valid), 32'd0);
      check("midrst_tile_cnt", 32'(tile_cnt), 32'd0);
      check("midrst_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      rst_n = 1'b1;
      obs_q.delete();
      send_tile(vecs[0], -1);
      wait_beats(4);
      for (int j = 0; j < 4; j++) pop_check("midrst_fresh", vecs[0].r[j], 1'b0);

      // Randomized traffic against the model.
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         in_data   = DW'($urandom);
         in_last   = ($urandom_range(0, 7) == 0);
         out_ready = ($urandom_range(0, 2) != 0);
         @(posedge clk); #1;
      end
      in_last = 1'b0;
      w = 0;
      while (part_q.size() != 0 && w < 100) begin
         in_valid = 1'b1;
         in_data  = DW'($urandom);
         @(posedge clk); #1;
         w++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      w = 0;
      while (exp_q.size() != 0 && w < 100) begin
         @(posedge clk); #1;
         w++;
      end
      repeat (3) @(posedge clk);
      #1;
      check("rand_drained", 32'(exp_q.size()), 32'd0);
      @(negedge clk);
      check("rand_idle", 32'(out_valid), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
